// File: rtl/cpu_pkg.sv
// Shared types for the forwarding / hazard logic: stall FSM states and
// the 2-bit operand-forward select encodings.
package cpu_pkg;

    typedef enum logic [1:0] {
        ST_RUN     = 2'd0,
        ST_STALL   = 2'd1,
        ST_TIMEOUT = 2'd2
    } hz_state_e;

    localparam logic [1:0] FWD_RF  = 2'b00;
    localparam logic [1:0] FWD_WB  = 2'b01;
    localparam logic [1:0] FWD_MEM = 2'b10;

endpackage

// File: rtl/src_forward.sv
// Per-source-operand compare: EX-stage forward select and ID-stage hazard
// detection (load-use against EX, or outstanding load in the scoreboard).
module src_forward
    import cpu_pkg::*;
#(
    parameter int REG_AW = 5
) (
    input  logic [REG_AW-1:0]      rs_ex,
    input  logic [REG_AW-1:0]      rd_mem,
    input  logic [REG_AW-1:0]      rd_wb,
    input  logic                   reg_write_mem,
    input  logic                   reg_write_wb,
    input  logic [REG_AW-1:0]      rs_id,
    input  logic                   rs_used,
    input  logic [REG_AW-1:0]      rd_ex,
    input  logic                   load_use_en,
    input  logic [2**REG_AW-1:0]   pending,
    output logic [1:0]             sel,
    output logic                   hz
);

    // MEM is the younger result, so it strictly wins over WB; r0 never forwards.
    always_comb begin
        sel = FWD_RF;
        if (rs_ex != '0) begin
            if (reg_write_mem && (rs_ex == rd_mem)) begin
                sel = FWD_MEM;
            end else if (reg_write_wb && (rs_ex == rd_wb)) begin
                sel = FWD_WB;
            end
        end
    end

    always_comb begin
        hz = 1'b0;
        if (rs_used && (rs_id != '0)) begin
            hz = (load_use_en && (rs_id == rd_ex)) || pending[rs_id];
        end
    end

endmodule

// File: rtl/forward_hazard_unit.sv
// Operand forwarding plus stall control: load-use and variable-latency load
// scoreboard hazards, a RUN/STALL/TIMEOUT watchdog FSM and stall statistics.
module forward_hazard_unit
    import cpu_pkg::*;
#(
    parameter int NUM_SRC     = 2,
    parameter int REG_AW      = 5,
    parameter int TIMEOUT_CYC = 64,
    parameter int CNT_W       = 16
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic [NUM_SRC*REG_AW-1:0] rs_ex,
    input  logic [NUM_SRC*REG_AW-1:0] rs_id,
    input  logic [NUM_SRC-1:0]        rs_used_id,
    input  logic [REG_AW-1:0]         rd_ex,
    input  logic [REG_AW-1:0]         rd_mem,
    input  logic [REG_AW-1:0]         rd_wb,
    input  logic                      reg_write_ex,
    input  logic                      reg_write_mem,
    input  logic                      reg_write_wb,
    input  logic                      mem_read_ex,
    input  logic                      ld_issue,
    input  logic [REG_AW-1:0]         ld_issue_rd,
    input  logic                      ld_done,
    input  logic [REG_AW-1:0]         ld_done_rd,
    output logic [NUM_SRC*2-1:0]      forward_sel,
    output logic                      stall_id,
    output logic                      bubble_ex,
    output logic [CNT_W-1:0]          stall_cycles,
    output logic                      timeout_err,
    output hz_state_e                 state_dbg
);

    localparam int NUM_REGS = 2**REG_AW;
    localparam int SC_W = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC) : 1;
    localparam logic [SC_W-1:0] STALL_LIM = SC_W'(TIMEOUT_CYC - 1);

    logic [NUM_REGS-1:0] pending_q, pending_d;
    hz_state_e           state_q, state_d;
    logic [SC_W-1:0]     consec_q, consec_d;
    logic [CNT_W-1:0]    stall_cycles_q, stall_cycles_d;
    logic [NUM_SRC-1:0]  src_hz;
    logic                hazard;

    for (genvar i = 0; i < NUM_SRC; i++) begin : g_src
        src_forward #(.REG_AW(REG_AW)) u_src (
            .rs_ex        (rs_ex[i*REG_AW +: REG_AW]),
            .rd_mem       (rd_mem),
            .rd_wb        (rd_wb),
            .reg_write_mem(reg_write_mem),
            .reg_write_wb (reg_write_wb),
            .rs_id        (rs_id[i*REG_AW +: REG_AW]),
            .rs_used      (rs_used_id[i]),
            .rd_ex        (rd_ex),
            .load_use_en  (mem_read_ex && reg_write_ex),
            .pending      (pending_q),
            .sel          (forward_sel[i*2 +: 2]),
            .hz           (src_hz[i])
        );
    end

    assign hazard = |src_hz;

    // Issue is applied after done so a same-register collision leaves the bit set.
    always_comb begin
        pending_d = pending_q;
        if (ld_done) begin
            pending_d[ld_done_rd] = 1'b0;
        end
        if (ld_issue) begin
            pending_d[ld_issue_rd] = 1'b1;
        end
        pending_d[0] = 1'b0;
    end

    always_comb begin
        state_d  = state_q;
        consec_d = consec_q;
        stall_id = hazard;
        unique case (state_q)
            ST_RUN: begin
                consec_d = '0;
                if (hazard) state_d = ST_STALL;
            end
            ST_STALL: begin
                if (!hazard) begin
                    state_d  = ST_RUN;
                    consec_d = '0;
                end else if (consec_q == STALL_LIM) begin
                    state_d = ST_TIMEOUT;
                end else begin
                    consec_d = consec_q + SC_W'(1);
                end
            end
            ST_TIMEOUT: begin
                stall_id = 1'b1;
            end
            default: begin
                state_d  = ST_RUN;
                consec_d = '0;
            end
        endcase
    end

    always_comb begin
        stall_cycles_d = stall_cycles_q;
        if (stall_id && (stall_cycles_q != {CNT_W{1'b1}})) begin
            stall_cycles_d = stall_cycles_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pending_q      <= '0;
            state_q        <= ST_RUN;
            consec_q       <= '0;
            stall_cycles_q <= '0;
        end else begin
            pending_q      <= pending_d;
            state_q        <= state_d;
            consec_q       <= consec_d;
            stall_cycles_q <= stall_cycles_d;
        end
    end

    assign bubble_ex    = stall_id;
    assign stall_cycles = stall_cycles_q;
    assign timeout_err  = (state_q == ST_TIMEOUT);
    assign state_dbg    = state_q;

endmodule

// File: tb/tb_forward_hazard_unit.sv
// Bench for forward_hazard_unit: a default-parameter instance (a) and a
// small instance (b: TIMEOUT_CYC=4, CNT_W=3) share one set of inputs.
module tb_forward_hazard_unit;
    import cpu_pkg::*;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst_n;
    logic [9:0]  rs_ex, rs_id;
    logic [1:0]  rs_used_id;
    logic [4:0]  rd_ex, rd_mem, rd_wb, ld_issue_rd, ld_done_rd;
    logic        reg_write_ex, reg_write_mem, reg_write_wb, mem_read_ex;
    logic        ld_issue, ld_done;

    logic [3:0]  fs_a, fs_b;
    logic        stall_a, bub_a, to_a, stall_b, bub_b, to_b;
    logic [15:0] sc_a;
    logic [2:0]  sc_b;
    hz_state_e   st_a, st_b;

    int checks = 0;
    int errors = 0;
    logic [5:0] exp_q[$];

    forward_hazard_unit u_dut_a (
        .clk(clk), .rst_n(rst_n), .rs_ex(rs_ex), .rs_id(rs_id), .rs_used_id(rs_used_id),
        .rd_ex(rd_ex), .rd_mem(rd_mem), .rd_wb(rd_wb), .reg_write_ex(reg_write_ex),
        .reg_write_mem(reg_write_mem), .reg_write_wb(reg_write_wb), .mem_read_ex(mem_read_ex),
        .ld_issue(ld_issue), .ld_issue_rd(ld_issue_rd), .ld_done(ld_done), .ld_done_rd(ld_done_rd),
        .forward_sel(fs_a), .stall_id(stall_a), .bubble_ex(bub_a), .stall_cycles(sc_a),
        .timeout_err(to_a), .state_dbg(st_a)
    );

    forward_hazard_unit #(.TIMEOUT_CYC(4), .CNT_W(3)) u_dut_b (
        .clk(clk), .rst_n(rst_n), .rs_ex(rs_ex), .rs_id(rs_id), .rs_used_id(rs_used_id),
        .rd_ex(rd_ex), .rd_mem(rd_mem), .rd_wb(rd_wb), .reg_write_ex(reg_write_ex),
        .reg_write_mem(reg_write_mem), .reg_write_wb(reg_write_wb), .mem_read_ex(mem_read_ex),
        .ld_issue(ld_issue), .ld_issue_rd(ld_issue_rd), .ld_done(ld_done), .ld_done_rd(ld_done_rd),
        .forward_sel(fs_b), .stall_id(stall_b), .bubble_ex(bub_b), .stall_cycles(sc_b),
        .timeout_err(to_b), .state_dbg(st_b)
    );

    typedef struct {
        logic [9:0] rs_ex;
        logic [4:0] rd_mem;
        logic [4:0] rd_wb;
        logic       wm;
        logic       ww;
        logic [9:0] rs_id;
        logic [1:0] used;
        logic [4:0] rd_ex;
        logic       mr;
        logic       we;
        logic [3:0] exp_fwd;
        logic       exp_stall;
    } vec_t;

    vec_t vecs [12];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h expected=%0h", nm, act, exp);
        end
    endtask

    task automatic sb_push(input logic [5:0] e);
        exp_q.push_back(e);
    endtask

    task automatic sb_pop(input string nm);
        logic [5:0] e;
        if (exp_q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL %s scoreboard empty", nm);
        end else begin
            e = exp_q.pop_front();
            chk(nm, {26'd0, fs_a, stall_a, bub_a}, {26'd0, e});
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_inputs();
        rs_ex = '0; rs_id = '0; rs_used_id = '0;
        rd_ex = '0; rd_mem = '0; rd_wb = '0;
        reg_write_ex = 1'b0; reg_write_mem = 1'b0; reg_write_wb = 1'b0; mem_read_ex = 1'b0;
        ld_issue = 1'b0; ld_issue_rd = '0; ld_done = 1'b0; ld_done_rd = '0;
    endtask

    task automatic apply_reset();
        rst_n = 1'b0;
        clear_inputs();
        #2;
        chk("rst_sc_a", 32'(sc_a), 0);
        chk("rst_to_a", 32'(to_a), 0);
        chk("rst_state_a", 32'(st_a), 32'(ST_RUN));
        chk("rst_sc_b", 32'(sc_b), 0);
        chk("rst_to_b", 32'(to_b), 0);
        @(negedge clk);
        rst_n = 1'b1;
        tick();
    endtask

    initial begin
        //          rs_ex          rd_mem rd_wb  wm    ww    rs_id          used   rd_ex  mr    we    fwd      stall
        vecs[0]  = '{{5'd3, 5'd5},  5'd5,  5'd5,  1'b1, 1'b1, 10'd0,         2'b00, 5'd0,  1'b0, 1'b0, 4'b0010, 1'b0};
        vecs[1]  = '{{5'd0, 5'd0},  5'd0,  5'd0,  1'b1, 1'b1, 10'd0,         2'b00, 5'd0,  1'b0, 1'b0, 4'b0000, 1'b0};
        vecs[2]  = '{{5'd6, 5'd6},  5'd7,  5'd6,  1'b1, 1'b1, 10'd0,         2'b00, 5'd0,  1'b0, 1'b0, 4'b0101, 1'b0};
        vecs[3]  = '{{5'd9, 5'd8},  5'd8,  5'd8,  1'b0, 1'b1, 10'd0,         2'b00, 5'd0,  1'b0, 1'b0, 4'b0001, 1'b0};
        vecs[4]  = '{{5'd13, 5'd12}, 5'd13, 5'd12, 1'b1, 1'b1, 10'd0,        2'b00, 5'd0,  1'b0, 1'b0, 4'b1001, 1'b0};
        vecs[5]  = '{{5'd4, 5'd4},  5'd4,  5'd4,  1'b0, 1'b0, 10'd0,         2'b00, 5'd0,  1'b0, 1'b0, 4'b0000, 1'b0};
        vecs[6]  = '{10'd0,         5'd0,  5'd0,  1'b0, 1'b0, {5'd7, 5'd2},  2'b10, 5'd7,  1'b1, 1'b1, 4'b0000, 1'b1};
        vecs[7]  = '{10'd0,         5'd0,  5'd0,  1'b0, 1'b0, {5'd7, 5'd2},  2'b01, 5'd7,  1'b1, 1'b1, 4'b0000, 1'b0};
        vecs[8]  = '{10'd0,         5'd0,  5'd0,  1'b0, 1'b0, {5'd0, 5'd7},  2'b01, 5'd7,  1'b0, 1'b1, 4'b0000, 1'b0};
        vecs[9]  = '{10'd0,         5'd0,  5'd0,  1'b0, 1'b0, {5'd0, 5'd7},  2'b01, 5'd7,  1'b1, 1'b0, 4'b0000, 1'b0};
        vecs[10] = '{10'd0,         5'd0,  5'd0,  1'b0, 1'b0, {5'd0, 5'd0},  2'b01, 5'd0,  1'b1, 1'b1, 4'b0000, 1'b0};
        vecs[11] = '{{5'd2, 5'd1},  5'd1,  5'd2,  1'b1, 1'b1, {5'd3, 5'd7},  2'b11, 5'd7,  1'b1, 1'b1, 4'b0110, 1'b1};

        // Load-use term is live even while reset is held.
        rst_n = 1'b0;
        clear_inputs();
        mem_read_ex = 1'b1; reg_write_ex = 1'b1; rd_ex = 5'd7;
        rs_id = {5'd0, 5'd7}; rs_used_id = 2'b01;
        #2;
        chk("rst_loaduse_stall_a", 32'(stall_a), 1);
        chk("rst_loaduse_bubble_b", 32'(bub_b), 1);
        apply_reset();

        for (int i = 0; i < 12; i++) begin
            rs_ex = vecs[i].rs_ex; rd_mem = vecs[i].rd_mem; rd_wb = vecs[i].rd_wb;
            reg_write_mem = vecs[i].wm; reg_write_wb = vecs[i].ww;
            rs_id = vecs[i].rs_id; rs_used_id = vecs[i].used; rd_ex = vecs[i].rd_ex;
            mem_read_ex = vecs[i].mr; reg_write_ex = vecs[i].we;
            sb_push({vecs[i].exp_fwd, vecs[i].exp_stall, vecs[i].exp_stall});
            #2;
            sb_pop($sformatf("vec%0d", i));
            tick();
        end

        // Variable-latency load to r9, returned on the fifth stall cycle.
        apply_reset();
        ld_issue = 1'b1; ld_issue_rd = 5'd9;
        rs_id = {5'd0, 5'd9}; rs_used_id = 2'b01;
        sb_push(6'b000000);
        #2;
        sb_pop("ld9_issue_cycle");
        tick();
        ld_issue = 1'b0;
        for (int k = 1; k <= 5; k++) begin
            if (k == 5) begin
                ld_done = 1'b1; ld_done_rd = 5'd9;
            end
            sb_push(6'b000011);
            #2;
            sb_pop($sformatf("ld9_stall%0d", k));
            tick();
        end
        ld_done = 1'b0;
        sb_push(6'b000000);
        #2;
        sb_pop("ld9_released");
        chk("ld9_stall_cycles", 32'(sc_a), 5);

        // Same-register issue/done collision, then different registers.
        apply_reset();
        ld_issue = 1'b1; ld_issue_rd = 5'd4; ld_done = 1'b1; ld_done_rd = 5'd4;
        tick();
        ld_issue = 1'b0; ld_done = 1'b0;
        rs_id = {5'd0, 5'd4}; rs_used_id = 2'b01;
        sb_push(6'b000011);
        #2;
        sb_pop("same_rd4_set");
        ld_issue = 1'b1; ld_issue_rd = 5'd5; ld_done = 1'b1; ld_done_rd = 5'd4;
        tick();
        ld_issue = 1'b0; ld_done = 1'b0;
        sb_push(6'b000000);
        #2;
        sb_pop("diff_rd4_cleared");
        rs_id = {5'd0, 5'd5};
        sb_push(6'b000011);
        #1;
        sb_pop("diff_rd5_set");
        ld_done = 1'b1; ld_done_rd = 5'd5;
        tick();
        ld_done = 1'b0;
        sb_push(6'b000000);
        #2;
        sb_pop("rd5_cleared");

        // Consecutive-stall counter must restart after a release (instance b).
        apply_reset();
        ld_issue = 1'b1; ld_issue_rd = 5'd10;
        rs_id = {5'd0, 5'd10}; rs_used_id = 2'b01;
        tick();
        ld_issue = 1'b0;
        for (int k = 1; k <= 3; k++) begin
            if (k == 3) begin
                ld_done = 1'b1; ld_done_rd = 5'd10;
            end
            tick();
        end
        ld_done = 1'b0;
        tick();
        ld_issue = 1'b1; ld_issue_rd = 5'd10;
        tick();
        ld_issue = 1'b0;
        for (int k = 1; k <= 4; k++) begin
            if (k == 4) begin
                ld_done = 1'b1; ld_done_rd = 5'd10;
            end
            #1;
            chk($sformatf("ep2_stall_b%0d", k), 32'(stall_b), 1);
            tick();
        end
        ld_done = 1'b0;
        chk("ep2_no_timeout", 32'(to_b), 0);
        #1;
        chk("ep2_released_b", 32'(stall_b), 0);

        // Held load to r3 on instance b: timeout after five stall cycles.
        apply_reset();
        ld_issue = 1'b1; ld_issue_rd = 5'd3;
        rs_id = {5'd0, 5'd3}; rs_used_id = 2'b01;
        tick();
        ld_issue = 1'b0;
        for (int k = 1; k <= 5; k++) begin
            #1;
            chk($sformatf("to_pre%0d", k), 32'(to_b), 0);
            chk($sformatf("to_stall%0d", k), 32'(stall_b), 1);
            tick();
        end
        chk("to_set", 32'(to_b), 1);
        chk("to_state", 32'(st_b), 32'(ST_TIMEOUT));
        chk("sc_b_after5", 32'(sc_b), 5);
        rs_used_id = 2'b00;
        rs_ex = {5'd0, 5'd5}; rd_mem = 5'd5; reg_write_mem = 1'b1;
        #1;
        chk("to_stall_held", 32'(stall_b), 1);
        chk("to_bubble_held", 32'(bub_b), 1);
        chk("fwd_in_timeout", 32'(fs_b[1:0]), 32'(FWD_MEM));
        for (int k = 0; k < 5; k++) tick();
        chk("sc_b_saturated", 32'(sc_b), 7);
        chk("to_persists", 32'(to_b), 1);

        // Asynchronous reset mid-cycle drops the outstanding load.
        #2;
        rst_n = 1'b0;
        reg_write_mem = 1'b0; rs_ex = '0;
        rs_used_id = 2'b01;
        #1;
        chk("arst_to_b", 32'(to_b), 0);
        chk("arst_state_b", 32'(st_b), 32'(ST_RUN));
        chk("arst_sc_b", 32'(sc_b), 0);
        chk("arst_stall_b", 32'(stall_b), 0);
        chk("arst_stall_a", 32'(stall_a), 0);
        @(negedge clk);
        rst_n = 1'b1;
        tick();
        ld_done = 1'b1; ld_done_rd = 5'd3;
        #1;
        chk("late_done_stall_b", 32'(stall_b), 0);
        tick();
        ld_done = 1'b0;
        #1;
        chk("late_done_after_b", 32'(stall_b), 0);
        chk("late_done_to_b", 32'(to_b), 0);

        if (exp_q.size() != 0) begin
            checks++;
            errors++;
            $display("FAIL sb_leftover actual=%0d expected=0", exp_q.size());
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
